// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: emits round keys 0..NUM_ROUNDS one at a time and uses a
// shared external S-box for the SubWord step of every round.
module aes_key_expansion #(
  parameter int WORD_DATA_WIDTH = 32,
  parameter int NUM_ROUNDS      = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [127:0]               key_in,
  input  logic                       key_in_vld,
  input  logic                       sbox_available,
  output logic [WORD_DATA_WIDTH-1:0] key_exp_val,
  output logic                       key_exp_val_vld,
  input  logic [WORD_DATA_WIDTH-1:0] key_exp_sbox_data,
  input  logic                       key_exp_sbox_data_vld,
  output logic [127:0]               round_key,
  output logic [3:0]                 round_key_idx,
  output logic                       round_key_vld,
  output logic                       key_exp_busy,
  output logic                       key_exp_done,
  output logic [1:0]                 debug_state
);

  // Handshakes: every *_vld is a single-cycle strobe with no backpressure.
  // sbox_available only gates issuing a request; once a request is out, the
  // response is awaited indefinitely and strobes outside WAIT_RESP are dropped.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EMIT      = 2'd1,
    REQ       = 2'd2,
    WAIT_RESP = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t state, state_next;

  logic [WORD_DATA_WIDTH-1:0] w0, w1, w2, w3;
  logic [WORD_DATA_WIDTH-1:0] t_word, n0, n1, n2, n3;
  logic [3:0]                 round_cnt;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Next-round words; the chain w0'->w1'->w2'->w3' completes in one edge.
  always_comb begin
    t_word = key_exp_sbox_data ^ {rcon(round_cnt), {(WORD_DATA_WIDTH-8){1'b0}}};
    n0     = w0 ^ t_word;
    n1     = w1 ^ n0;
    n2     = w2 ^ n1;
    n3     = w3 ^ n2;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (key_in_vld) state_next = EMIT;
      EMIT:      state_next = (round_cnt == LAST_ROUND) ? IDLE : REQ;
      REQ:       if (sbox_available) state_next = WAIT_RESP;
      WAIT_RESP: if (key_exp_sbox_data_vld) state_next = EMIT;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w0              <= '0;
      w1              <= '0;
      w2              <= '0;
      w3              <= '0;
      round_cnt       <= '0;
      round_key       <= '0;
      round_key_idx   <= '0;
      round_key_vld   <= 1'b0;
      key_exp_val     <= '0;
      key_exp_val_vld <= 1'b0;
      key_exp_busy    <= 1'b0;
      key_exp_done    <= 1'b0;
    end else begin
      round_key_vld   <= 1'b0;
      key_exp_val_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (key_in_vld) begin
            w0           <= key_in[127:96];
            w1           <= key_in[95:64];
            w2           <= key_in[63:32];
            w3           <= key_in[31:0];
            round_cnt    <= '0;
            key_exp_busy <= 1'b1;
            key_exp_done <= 1'b0;
          end
        end
        EMIT: begin
          round_key     <= {w0, w1, w2, w3};
          round_key_idx <= round_cnt;
          round_key_vld <= 1'b1;
          if (round_cnt == LAST_ROUND) begin
            key_exp_busy <= 1'b0;
            key_exp_done <= 1'b1;
          end else begin
            round_cnt <= round_cnt + 4'd1;
          end
        end
        REQ: begin
          if (sbox_available) begin
            key_exp_val     <= {w3[WORD_DATA_WIDTH-9:0], w3[WORD_DATA_WIDTH-1:WORD_DATA_WIDTH-8]};
            key_exp_val_vld <= 1'b1;
          end
        end
        WAIT_RESP: begin
          if (key_exp_sbox_data_vld) begin
            w0 <= n0;
            w1 <= n1;
            w2 <= n2;
            w3 <= n3;
          end
        end
        default: ;
      endcase
    end
  end

  assign debug_state = state;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: an S-box responder model, a round
// key / request scoreboard fed by an independent key-schedule model, and scenario tasks.
module tb_aes_key_expansion;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_in_vld = 1'b0;
  logic         sbox_available = 1'b1;
  logic [31:0]  key_exp_val;
  logic         key_exp_val_vld;
  logic [31:0]  key_exp_sbox_data = '0;
  logic         key_exp_sbox_data_vld = 1'b0;
  logic [127:0] round_key;
  logic [3:0]   round_key_idx;
  logic         round_key_vld;
  logic         key_exp_busy;
  logic         key_exp_done;
  logic [1:0]   debug_state;

  aes_key_expansion dut (
    .clock                 (clock),
    .reset                 (reset),
    .key_in                (key_in),
    .key_in_vld            (key_in_vld),
    .sbox_available        (sbox_available),
    .key_exp_val           (key_exp_val),
    .key_exp_val_vld       (key_exp_val_vld),
    .key_exp_sbox_data     (key_exp_sbox_data),
    .key_exp_sbox_data_vld (key_exp_sbox_data_vld),
    .round_key             (round_key),
    .round_key_idx         (round_key_idx),
    .round_key_vld         (round_key_vld),
    .key_exp_busy          (key_exp_busy),
    .key_exp_done          (key_exp_done),
    .debug_state           (debug_state)
  );

  always #5 clock = ~clock;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_IDX1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_IDX10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_IDX1 = 128'h62636363626363636263636362636363;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [131:0] exp_q[$];
  logic [31:0]  req_q[$];
  logic [131:0] mon_e;
  logic [31:0]  mon_r;
  logic [127:0] obs_keys [0:10];
  int           obs_cnt = 0;
  int           req_cnt = 0;
  logic [31:0]  first_req = '0;
  logic [7:0]   sbox_tab [0:255];

  int          fixed_lat = 2;
  bit          rand_lat  = 1'b0;
  bit          spur_en   = 1'b0;
  bit          rsp_pending = 1'b0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_val = '0;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // S-box from the field inverse plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_push(input logic [127:0] key);
    logic [31:0] w0, w1, w2, w3, rot, t;
    logic [7:0]  rc;
    w0 = key[127:96]; w1 = key[95:64]; w2 = key[63:32]; w3 = key[31:0];
    rc = 8'h01;
    exp_q.push_back({4'd0, key});
    for (int r = 1; r <= 10; r++) begin
      rot = {w3[23:0], w3[31:24]};
      req_q.push_back(rot);
      t  = sub_word(rot) ^ {rc, 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      exp_q.push_back({4'(r), w0, w1, w2, w3});
      rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
    end
  endtask

  // S-box responder: answers each request after a latency; may inject stray strobes.
  initial begin
    forever begin
      @(negedge clock);
      key_exp_sbox_data_vld = 1'b0;
      if (rsp_pending) begin
        if (rsp_cnt <= 1) begin
          key_exp_sbox_data     = sub_word(rsp_val);
          key_exp_sbox_data_vld = 1'b1;
          rsp_pending           = 1'b0;
        end else begin
          rsp_cnt--;
        end
      end else if (key_exp_val_vld) begin
        rsp_val     = key_exp_val;
        rsp_pending = 1'b1;
        rsp_cnt     = rand_lat ? int'($urandom_range(1, 15)) : fixed_lat;
      end else if (spur_en && $urandom_range(0, 2) == 0) begin
        key_exp_sbox_data     = $urandom;
        key_exp_sbox_data_vld = 1'b1;
      end
    end
  end

  // Scoreboard: pop expected round keys / requests as the DUT produces them.
  initial begin
    forever begin
      @(negedge clock);
      if (round_key_vld) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL round_key_unexpected: got idx %0d key %h, required no strobe", round_key_idx, round_key);
        end else begin
          mon_e = exp_q.pop_front();
          if ({round_key_idx, round_key} !== mon_e)
            $display("FAIL round_key: got idx %0d key %h, required idx %0d key %h",
                     round_key_idx, round_key, mon_e[131:128], mon_e[127:0]);
          else pass_cnt++;
        end
        if (round_key_idx <= 4'd10) obs_keys[round_key_idx] = round_key;
        obs_cnt++;
      end
      if (key_exp_val_vld) begin
        total_cnt++;
        if (req_cnt == 0) first_req = key_exp_val;
        req_cnt++;
        if (req_q.size() == 0) begin
          $display("FAIL sbox_req_unexpected: got %h, required no strobe", key_exp_val);
        end else begin
          mon_r = req_q.pop_front();
          if (key_exp_val !== mon_r)
            $display("FAIL sbox_req: got %h, required %h", key_exp_val, mon_r);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic start_key(input logic [127:0] key, input bit accept);
    if (accept) model_push(key);
    @(negedge clock);
    key_in     = key;
    key_in_vld = 1'b1;
    @(negedge clock);
    key_in_vld = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (key_exp_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    total_cnt++;
    if (key_exp_done !== 1'b1) $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, key_exp_done, n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    total_cnt++;
    if ({round_key_idx, round_key} !== 132'h0) $display("FAIL reset_round_key: got %h/%0d, required 0/0", round_key, round_key_idx);
    else pass_cnt++;
    total_cnt++;
    if (key_exp_val !== 32'h0) $display("FAIL reset_key_exp_val: got %h, required 0", key_exp_val);
    else pass_cnt++;
    total_cnt++;
    if ({round_key_vld, key_exp_val_vld, key_exp_busy, key_exp_done} !== 4'b0)
      $display("FAIL reset_flags: got %b, required 0000", {round_key_vld, key_exp_val_vld, key_exp_busy, key_exp_done});
    else pass_cnt++;
    total_cnt++;
    if (debug_state !== 2'd0) $display("FAIL reset_state: got %0d, required 0", debug_state);
    else pass_cnt++;
  endtask

  task automatic test_fips_a1();
    fixed_lat = 2; rand_lat = 1'b0; spur_en = 1'b0; sbox_available = 1'b1;
    obs_cnt = 0; req_cnt = 0;
    start_key(KEY_A1, 1'b1);
    #1;
    total_cnt++;
    if ({key_exp_busy, key_exp_done} !== 2'b10) $display("FAIL a1_busy_at_start: got busy/done %b, required 10", {key_exp_busy, key_exp_done});
    else pass_cnt++;
    wait_done(400, "a1");
    total_cnt++;
    if (obs_keys[0] !== KEY_A1) $display("FAIL a1_idx0: got %h, required %h", obs_keys[0], KEY_A1);
    else pass_cnt++;
    total_cnt++;
    if (first_req !== 32'hcf4f3c09) $display("FAIL a1_first_req: got %h, required cf4f3c09", first_req);
    else pass_cnt++;
    total_cnt++;
    if (obs_keys[1] !== A1_IDX1) $display("FAIL a1_idx1: got %h, required %h", obs_keys[1], A1_IDX1);
    else pass_cnt++;
    total_cnt++;
    if (obs_keys[10] !== A1_IDX10) $display("FAIL a1_idx10: got %h, required %h", obs_keys[10], A1_IDX10);
    else pass_cnt++;
    total_cnt++;
    if ({key_exp_busy, key_exp_done} !== 2'b01) $display("FAIL a1_done_flags: got busy/done %b, required 01", {key_exp_busy, key_exp_done});
    else pass_cnt++;
    total_cnt++;
    if (req_cnt !== 10 || obs_cnt !== 11) $display("FAIL a1_counts: got %0d req %0d keys, required 10 req 11 keys", req_cnt, obs_cnt);
    else pass_cnt++;
  endtask

  task automatic test_sbox_stall();
    fixed_lat = 2; rand_lat = 1'b0; spur_en = 1'b0;
    sbox_available = 1'b0;
    obs_cnt = 0; req_cnt = 0;
    start_key(KEY_A1, 1'b1);
    repeat (20) tick();
    total_cnt++;
    if (req_cnt !== 0 || obs_cnt !== 1) $display("FAIL stall_hold: got %0d req %0d keys, required 0 req 1 key", req_cnt, obs_cnt);
    else pass_cnt++;
    sbox_available = 1'b1;
    tick();
    total_cnt++;
    if (key_exp_val_vld !== 1'b1 || key_exp_val !== 32'hcf4f3c09)
      $display("FAIL stall_release_req: got vld %b val %h, required 1 cf4f3c09", key_exp_val_vld, key_exp_val);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (key_exp_val_vld !== 1'b0 || key_exp_val !== 32'hcf4f3c09)
      $display("FAIL stall_single_strobe: got vld %b val %h, required 0 cf4f3c09", key_exp_val_vld, key_exp_val);
    else pass_cnt++;
    wait_done(400, "stall");
    total_cnt++;
    if (obs_keys[10] !== A1_IDX10 || req_cnt !== 10) $display("FAIL stall_idx10: got %h req %0d, required %h req 10", obs_keys[10], req_cnt, A1_IDX10);
    else pass_cnt++;
  endtask

  task automatic test_random_latency();
    logic [127:0] k;
    int n;
    rand_lat = 1'b1; spur_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      start_key(k, 1'b1);
      n = 0;
      while (key_exp_done !== 1'b1 && n < 2000) begin
        tick();
        sbox_available = ($urandom_range(0, 3) != 0);
        n++;
      end
      sbox_available = 1'b1;
      total_cnt++;
      if (key_exp_done !== 1'b1 || exp_q.size() != 0 || req_q.size() != 0)
        $display("FAIL random_run%0d: got done %b pending keys %0d reqs %0d, required 1 0 0", i, key_exp_done, exp_q.size(), req_q.size());
      else pass_cnt++;
    end
    rand_lat = 1'b0; spur_en = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_busy_restart();
    logic [127:0] ka, kb;
    int n;
    fixed_lat = int'($urandom_range(1, 6)); rand_lat = 1'b0; spur_en = 1'b0;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    obs_cnt = 0;
    start_key(ka, 1'b1);
    for (int stop = 4; stop <= 8; stop += 4) begin
      n = 0;
      while (obs_cnt < stop && n < 500) begin tick(); n++; end
      total_cnt++;
      if (obs_cnt < stop) $display("FAIL busy_reach_round%0d: got %0d keys, required %0d", stop - 1, obs_cnt, stop);
      else pass_cnt++;
      key_in = kb; key_in_vld = 1'b1;
      tick();
      key_in_vld = 1'b0;
    end
    wait_done(400, "busy");
    total_cnt++;
    if (obs_keys[0] !== ka || exp_q.size() != 0 || obs_cnt !== 11)
      $display("FAIL busy_no_restart: got idx0 %h keys %0d pending %0d, required %h 11 0", obs_keys[0], obs_cnt, exp_q.size(), ka);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fixed_lat = 12; rand_lat = 1'b0; spur_en = 1'b0;
    req_cnt = 0;
    start_key(KEY_A1, 1'b1);
    while (req_cnt < 5 && n < 500) begin tick(); n++; end
    tick();
    total_cnt++;
    if (req_cnt !== 5 || debug_state !== 2'd3) $display("FAIL midreset_reach: got req %0d state %0d, required 5 3", req_cnt, debug_state);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    exp_q.delete();
    req_q.delete();
    total_cnt++;
    if ({round_key, round_key_idx, key_exp_val} !== 164'h0 ||
        {round_key_vld, key_exp_val_vld, key_exp_busy, key_exp_done} !== 4'b0 || debug_state !== 2'd0)
      $display("FAIL midreset_async: got key %h idx %0d val %h flags %b state %0d, required all 0", round_key, round_key_idx,
               key_exp_val, {round_key_vld, key_exp_val_vld, key_exp_busy, key_exp_done}, debug_state);
    else pass_cnt++;
    repeat (2) tick();
    reset = 1'b1;
    obs_cnt = 0;
    repeat (20) tick();
    total_cnt++;
    if (round_key !== 128'h0 || key_exp_busy !== 1'b0 || debug_state !== 2'd0 || obs_cnt !== 0 || rsp_pending)
      $display("FAIL midreset_late_resp: got key %h busy %b state %0d keys %0d, required 0 0 0 0", round_key, key_exp_busy, debug_state, obs_cnt);
    else pass_cnt++;
    fixed_lat = 2;
    start_key(128'h0, 1'b1);
    wait_done(400, "zero_key");
    total_cnt++;
    if (obs_keys[1] !== ZERO_IDX1) $display("FAIL zero_key_idx1: got %h, required %h", obs_keys[1], ZERO_IDX1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka, kb, kc;
    int n = 0;
    fixed_lat = 3; rand_lat = 1'b0; spur_en = 1'b0;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    kc = ka ^ kb;
    req_cnt = 0;
    start_key(ka, 1'b1);
    while (!(req_cnt == 10 && key_exp_sbox_data_vld) && n < 500) begin tick(); n++; end
    total_cnt++;
    if (req_cnt !== 10 || key_exp_sbox_data_vld !== 1'b1) $display("FAIL b2b_last_resp: got req %0d, required 10", req_cnt);
    else pass_cnt++;
    key_in = kc; key_in_vld = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({key_exp_busy, key_exp_done} !== 2'b01) $display("FAIL b2b_done_rise: got busy/done %b, required 01", {key_exp_busy, key_exp_done});
    else pass_cnt++;
    model_push(kb);
    key_in = kb;
    tick();
    key_in_vld = 1'b0;
    total_cnt++;
    if ({key_exp_busy, key_exp_done} !== 2'b10) $display("FAIL b2b_capture: got busy/done %b, required 10", {key_exp_busy, key_exp_done});
    else pass_cnt++;
    wait_done(400, "b2b");
    total_cnt++;
    if (exp_q.size() != 0 || req_q.size() != 0) $display("FAIL b2b_complete: got pending keys %0d reqs %0d, required 0 0", exp_q.size(), req_q.size());
    else pass_cnt++;
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_a1();
    test_sbox_stall();
    test_random_latency();
    test_busy_restart();
    test_reset_mid();
    test_back_to_back();
    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
